// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one SPI engine among NREQ requesters.
// Frames chip-select with setup/guard spacing, pulses the engine start and aborts hung transfers.
module spi_xfer_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_GUARD = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_dir,
  input  logic [8*NREQ-1:0]       req_wdata,
  output logic [NREQ-1:0]         done,
  output logic                    err,
  output logic [7:0]              rdata,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    eng_cs_n,
  output logic                    eng_tx_start,
  output logic                    eng_rx_start,
  output logic [7:0]              eng_wdata,
  input  logic [7:0]              eng_rdata,
  input  logic                    eng_rx_valid,
  input  logic                    eng_tx_done
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned CW = 4;
  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GUARD = 3'd4;

  logic [2:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [OW-1:0] ptr, ptr_nx, owner_nx, ptr_inc;
  logic          dir_q, dir_nx;
  logic [7:0]    wdata_q, wdata_nx, rdata_q, rdata_nx;

  logic          found;
  logic [OW-1:0] win, cand;
  logic          hit, tmo;

  // First set request at or after ptr, scanning upward with wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = OW'((32'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Only the event matching the latched direction completes; the other is ignored.
  assign hit     = (state == S_WAIT) && (dir_q ? eng_rx_valid : eng_tx_done);
  assign tmo     = (state == S_WAIT) && !hit && (tcnt == TW'(TIMEOUT - 1));
  assign ptr_inc = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    done = '0;
    if (hit || tmo) done[owner] = 1'b1;
  end

  assign err          = tmo;
  assign rdata        = (hit && dir_q) ? eng_rdata : rdata_q;
  assign busy         = (state != S_IDLE);
  assign eng_cs_n     = !((state == S_SETUP) || (state == S_START) || (state == S_WAIT));
  assign eng_tx_start = (state == S_START) && !dir_q;
  assign eng_rx_start = (state == S_START) && dir_q;
  assign eng_wdata    = wdata_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tcnt_nx  = tcnt;
    ptr_nx   = ptr;
    owner_nx = owner;
    dir_nx   = dir_q;
    wdata_nx = wdata_q;
    rdata_nx = rdata_q;
    case (state)
      S_IDLE: begin
        if (found) begin
          owner_nx = win;
          dir_nx   = req_dir[win];
          wdata_nx = req_wdata[{win, 3'b000} +: 8];
          cnt_nx   = CW'(CS_SETUP);
          state_nx = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt <= CW'(1)) state_nx = S_START;
        else               cnt_nx   = cnt - 1'b1;
      end
      S_START: begin
        tcnt_nx  = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (hit || tmo) begin
          if (hit && dir_q) rdata_nx = eng_rdata;
          ptr_nx   = ptr_inc;
          cnt_nx   = CW'(CS_GUARD);
          state_nx = S_GUARD;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt <= CW'(1)) state_nx = S_IDLE;
        else               cnt_nx   = cnt - 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      tcnt    <= '0;
      ptr     <= '0;
      owner   <= '0;
      dir_q   <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      tcnt    <= tcnt_nx;
      ptr     <= ptr_nx;
      owner   <= owner_nx;
      dir_q   <= dir_nx;
      wdata_q <= wdata_nx;
      rdata_q <= rdata_nx;
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter: a round-robin grant-order model fills an expectation
// queue, a behavioural engine answers start pulses, and a monitor checks every completion.
module tb_spi_xfer_arbiter;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_GUARD = 2;
  localparam int unsigned TIMEOUT  = 64;
  localparam int unsigned OW       = $clog2(NREQ);

  logic                 clk, rst_n;
  logic [NREQ-1:0]      req, req_dir;
  logic [8*NREQ-1:0]    req_wdata;
  logic [NREQ-1:0]      done;
  logic                 err, busy;
  logic [7:0]           rdata;
  logic [OW-1:0]        owner;
  logic                 eng_cs_n, eng_tx_start, eng_rx_start;
  logic [7:0]           eng_wdata, eng_rdata;
  logic                 eng_rx_valid, eng_tx_done;

  spi_xfer_arbiter #(.NREQ(NREQ), .CS_SETUP(CS_SETUP), .CS_GUARD(CS_GUARD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dir(req_dir), .req_wdata(req_wdata),
    .done(done), .err(err), .rdata(rdata), .busy(busy), .owner(owner),
    .eng_cs_n(eng_cs_n), .eng_tx_start(eng_tx_start), .eng_rx_start(eng_rx_start),
    .eng_wdata(eng_wdata), .eng_rdata(eng_rdata), .eng_rx_valid(eng_rx_valid),
    .eng_tx_done(eng_tx_done)
  );

  typedef struct {
    int         idx;
    bit         dir;
    logic [7:0] wdata;
    logic [7:0] rdata;
    bit         err;
    int         wl;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         p_dir[NREQ];
  logic [7:0] p_wd[NREQ];
  logic [7:0] p_rb[NREQ];
  int         p_d[NREQ];
  int         p_wk[NREQ];
  int         m_ptr = 0;
  logic [7:0] m_rdata = 8'h00;
  int         poke_cnt = 0;
  bit         eng_on = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual cycle %0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_plan(input int i, input bit dir, input logic [7:0] wd, input int d,
                          input logic [7:0] rb, input int wk);
    p_dir[i] = dir; p_wd[i] = wd; p_d[i] = d; p_rb[i] = rb; p_wk[i] = wk;
  endtask

  // Engine: answers in WAIT cycle d (d outside 1..TIMEOUT = never), optionally a wrong event at wk.
  initial begin : engine
    int k, cd, cwk, poke_seen;
    bit cdir;
    logic [7:0] crb;
    eng_tx_done = 0; eng_rx_valid = 0; eng_rdata = 8'h00;
    k = 0; cd = 0; cwk = 0; cdir = 0; crb = 8'h00; poke_seen = 0;
    forever begin
      @(negedge clk);
      if (rst_n && (eng_tx_start || eng_rx_start)) begin
        eng_on = 1'b1; k = 0;
        cd = p_d[owner]; cwk = p_wk[owner]; crb = p_rb[owner]; cdir = eng_rx_start;
      end
      @(posedge clk); #1;
      eng_tx_done = 0; eng_rx_valid = 0;
      if (eng_on) begin
        k++;
        if (k == cd) begin
          if (cdir) begin eng_rx_valid = 1; eng_rdata = crb; end
          else eng_tx_done = 1;
          eng_on = 1'b0;
        end else if (k == cwk) begin
          if (cdir) eng_tx_done = 1;
          else begin eng_rx_valid = 1; eng_rdata = 8'($urandom); end
        end
        if (k >= int'(TIMEOUT)) eng_on = 1'b0;
      end else if (poke_seen != poke_cnt) begin
        poke_seen = poke_cnt;
        eng_tx_done = 1; eng_rx_valid = 1; eng_rdata = 8'hEE;
      end
    end
  end

  initial begin : monitor
    int low_run, high_run, guard_run, start_cyc, exp_low;
    bit chk_rise, b2b;
    exp_t e;
    low_run = 0; high_run = 0; guard_run = 0; start_cyc = 0; exp_low = 0; chk_rise = 0; b2b = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low_run = 0; high_run = 0; guard_run = 0; chk_rise = 0; b2b = 0;
        continue;
      end
      if (eng_tx_start || eng_rx_start) begin
        chk("start_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          chk("start_rx", 32'(eng_rx_start), 32'(exp_q[0].dir));
          chk("start_tx", 32'(eng_tx_start), 32'(!exp_q[0].dir));
          chk("setup_len", 32'(low_run), 32'(CS_SETUP));
          chk("start_wdata", 32'(eng_wdata), 32'(exp_q[0].wdata));
        end
        start_cyc = cyc;
      end
      if (err) chk("err_has_done", 32'(done != 0), 32'(1));
      if (done != 0) begin
        chk("done_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("done_onehot", 32'(done), 32'(1) << e.idx);
          chk("owner", 32'(owner), 32'(e.idx));
          chk("err", 32'(err), 32'(e.err));
          chk("rdata_done", 32'(rdata), 32'(e.rdata));
          chk("wdata_done", 32'(eng_wdata), 32'(e.wdata));
          chk("cs_low_at_done", 32'(eng_cs_n), 32'(0));
          chk("wait_len", 32'(cyc - start_cyc), 32'(e.wl));
          chk_rise = 1; exp_low = CS_SETUP + 1 + e.wl;
          b2b = (exp_q.size() != 0);
        end
      end else if (chk_rise) begin
        chk("cs_rise", 32'(eng_cs_n), 32'(1));
        chk("cs_low_len", 32'(low_run), 32'(exp_low));
        chk("rdata_hold", 32'(rdata), 32'(m_rdata_at_pop(e)));
        chk_rise = 0;
      end
      if (!eng_cs_n && high_run > 0 && b2b) begin
        chk("guard_len", 32'(guard_run), 32'(CS_GUARD));
        chk("cs_high_gap", 32'(high_run), 32'(CS_GUARD + 1));
        b2b = 0;
      end
      if (eng_cs_n) begin
        high_run++; low_run = 0;
        if (busy) guard_run++;
      end else begin
        low_run++; high_run = 0; guard_run = 0;
      end
    end
  end

  function automatic logic [7:0] m_rdata_at_pop(input exp_t e);
    return e.rdata;
  endfunction

  // Reference: held requests are served in wrap-around order starting at the model pointer.
  task automatic run_batch(input logic [NREQ-1:0] set, input bit withdraw);
    int last, left, budget;
    logic [NREQ-1:0] d;
    exp_t e;
    last = -1; left = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      int i;
      i = (m_ptr + k) % int'(NREQ);
      if (set[i]) begin
        e.idx = i; e.dir = p_dir[i]; e.wdata = p_wd[i];
        e.err = !(p_d[i] >= 1 && p_d[i] <= int'(TIMEOUT));
        e.wl  = e.err ? int'(TIMEOUT) : p_d[i];
        if (!e.err && p_dir[i]) m_rdata = p_rb[i];
        e.rdata = m_rdata;
        exp_q.push_back(e);
        last = i; left++;
      end
    end
    if (last >= 0) m_ptr = (last + 1) % int'(NREQ);
    for (int i = 0; i < int'(NREQ); i++) begin
      req_dir[i] = p_dir[i];
      req_wdata[8*i +: 8] = p_wd[i];
    end
    req = set;
    budget = 0;
    while (left > 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (withdraw && (eng_tx_start || eng_rx_start) && exp_q.size() != 0) begin
        d = NREQ'(1) << exp_q[0].idx;
        @(posedge clk); #1;
        req &= ~d;
      end else if (done != 0) begin
        d = done;
        left--;
        @(posedge clk); #1;
        req &= ~d;
      end
    end
    chk("batch_complete", 32'(left), 32'(0));
    req = '0;
    repeat (CS_GUARD + 2) @(posedge clk);
    #1;
    chk("idle_after", 32'(busy), 32'(0));
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    chk("rdata_held", 32'(rdata), 32'(m_rdata));
  endtask

  task automatic poke();
    poke_cnt++;
    repeat (3) @(posedge clk);
    #1;
    chk("poke_ignored", 32'(busy), 32'(0));
  endtask

  initial begin : stim
    exp_t e;
    int budget;
    rst_n = 1'b0; req = '0; req_dir = '0; req_wdata = '0;
    for (int i = 0; i < int'(NREQ); i++) set_plan(i, 0, 8'h00, 1, 8'h00, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(eng_cs_n), 32'(1));
    chk("rst_tx", 32'(eng_tx_start), 32'(0));
    chk("rst_rx", 32'(eng_rx_start), 32'(0));
    chk("rst_wdata", 32'(eng_wdata), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_owner", 32'(owner), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    set_plan(2, 0, 8'hA5, 5, 8'h00, 0);
    run_batch(4'b0100, 0);
    set_plan(1, 1, 8'h11, 3, 8'h3C, 0);
    run_batch(4'b0010, 0);
    for (int i = 0; i < int'(NREQ); i++)
      set_plan(i, 1'($urandom), 8'($urandom), int'($urandom_range(1, 4)), 8'($urandom), 0);
    run_batch(4'b1111, 0);
    run_batch(4'b1001, 0);
    set_plan(0, 1, 8'h42, 0, 8'hFF, 0);
    run_batch(4'b0001, 0);
    set_plan(2, 0, 8'h24, 2, 8'h00, 0);
    run_batch(4'b0100, 0);
    set_plan(3, 1, 8'h99, int'(TIMEOUT), 8'h77, 0);
    run_batch(4'b1000, 0);
    set_plan(0, 0, 8'h5B, 6, 8'h00, 2);
    set_plan(1, 1, 8'h6C, 4, 8'h5E, 1);
    run_batch(4'b0011, 1);
    poke();

    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        int r, d, wk;
        r  = int'($urandom_range(0, 9));
        d  = (r == 0) ? 0 : (r == 1) ? int'(TIMEOUT) : int'($urandom_range(1, 10));
        wk = 0;
        if ((d == 0 || d >= 2) && $urandom_range(0, 2) == 0)
          wk = int'($urandom_range(1, (d == 0) ? 20 : d - 1));
        set_plan(i, 1'($urandom), 8'($urandom), d, 8'($urandom), wk);
      end
      if (b % 8 == 0) poke();
      run_batch(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'($urandom));
    end

    // Reset in the middle of a hung transmit.
    set_plan(1, 0, 8'h5A, 0, 8'h00, 0);
    req_dir[1] = 1'b0; req_wdata[15:8] = 8'h5A;
    e.idx = 1; e.dir = 0; e.wdata = 8'h5A; e.rdata = m_rdata; e.err = 1; e.wl = int'(TIMEOUT);
    exp_q.push_back(e);
    req = 4'b0010;
    budget = 0;
    while (!(eng_tx_start || eng_rx_start) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("rst_test_started", 32'(budget < 200), 32'(1));
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", 32'(eng_cs_n), 32'(1));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_tx", 32'(eng_tx_start), 32'(0));
    chk("midrst_rx", 32'(eng_rx_start), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_err", 32'(err), 32'(0));
    chk("midrst_owner", 32'(owner), 32'(0));
    chk("midrst_rdata", 32'(rdata), 32'(0));
    exp_q.delete();
    req = '0; m_ptr = 0; m_rdata = 8'h00;
    budget = 0;
    while (eng_on && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    set_plan(3, 1, 8'hC3, 4, 8'h96, 0);
    run_batch(4'b1000, 0);
    set_plan(1, 0, 8'h31, 2, 8'h00, 0);
    set_plan(2, 1, 8'h32, 3, 8'h4D, 0);
    run_batch(4'b0110, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
